// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word handshake between a bitstream source and ccff_bitstream_loader.
// The source drives data/valid; the loader answers with ready.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;

  modport master (output bs_data, output bs_valid, input bs_ready);
  modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto a configuration chain's ccff_head.
// Define CCFF_READBACK_EN to also rebuild the chain's previous contents from ccff_tail.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset,
  input  logic                   start,
  ccff_bitstream_loader_if.slave bs,
  output logic                   ccff_head,
  output logic                   ccff_shift_en,
  input  logic                   ccff_tail,
  output logic                   busy,
  output logic                   cfg_done,
  output logic [WORD_W-1:0]      rb_data,
  output logic                   rb_valid
);

  localparam int BIW_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  remaining;     // chain bits not yet clocked in
  logic [BIW_W-1:0]  bits_in_word;  // bits of the current word still to present, incl. ccff_head
  logic [WORD_W-1:0] shreg;         // bits queued behind ccff_head

  // The final word may cover fewer than WORD_W chain bits.
  function automatic logic [BIW_W-1:0] word_bits(input logic [CNT_W-1:0] left);
    if (int'(left) >= WORD_W) return BIW_W'(WORD_W);
    else                      return BIW_W'(left);
  endfunction

  // NOTE: non-blocking assignments only; every decision below reads pre-edge register values.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state         <= IDLE;
      remaining     <= '0;
      bits_in_word  <= '0;
      shreg         <= '0;
      bs.bs_ready   <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      cfg_done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= WAIT;
            remaining   <= CNT_W'(CHAIN_LEN);
            busy        <= 1'b1;
            cfg_done    <= 1'b0;
            bs.bs_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (bs.bs_valid) begin
            state         <= SHIFT;
            ccff_head     <= bs.bs_data[WORD_W-1];
            shreg         <= bs.bs_data << 1;
            bits_in_word  <= word_bits(remaining);
            ccff_shift_en <= 1'b1;
            bs.bs_ready   <= 1'b0;
          end
        end
        SHIFT: begin
          remaining <= remaining - CNT_W'(1);
          if (bits_in_word != BIW_W'(1)) begin
            ccff_head    <= shreg[WORD_W-1];
            shreg        <= shreg << 1;
            bits_in_word <= bits_in_word - BIW_W'(1);
            // NOTE: ready is registered, so it is raised one cycle ahead of the last-bit cycle.
            bs.bs_ready  <= (bits_in_word == BIW_W'(2)) && (int'(remaining) > 2);
          end else if (remaining == CNT_W'(1)) begin
            state         <= DONE;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            cfg_done      <= 1'b1;
            bs.bs_ready   <= 1'b0;
          end else if (bs.bs_valid && bs.bs_ready) begin
            ccff_head    <= bs.bs_data[WORD_W-1];
            shreg        <= bs.bs_data << 1;
            bits_in_word <= word_bits(remaining - CNT_W'(1));
            bs.bs_ready  <= 1'b0;
          end else begin
            // Bubble: the chain clock stops and ccff_head keeps the last bit.
            state         <= WAIT;
            ccff_shift_en <= 1'b0;
            bs.bs_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_acc;
  logic [BIW_W-1:0]  rb_cnt;
  logic [WORD_W-1:0] rb_word;
  logic [BIW_W-1:0]  rb_cnt_nxt;

  always_comb begin
    rb_word    = {rb_acc[WORD_W-2:0], ccff_tail};
    rb_cnt_nxt = rb_cnt + BIW_W'(1);
  end

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      rb_acc   <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (ccff_shift_en) begin
        rb_acc <= rb_word;
        // A short final word is left-aligned; the shift also pushes out stale upper bits.
        if (rb_cnt_nxt == BIW_W'(WORD_W) || remaining == CNT_W'(1)) begin
          rb_data  <= rb_word << (WORD_W - int'(rb_cnt_nxt));
          rb_valid <= 1'b1;
          rb_cnt   <= '0;
        end else begin
          rb_cnt <= rb_cnt_nxt;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: a 16-bit and a 12-bit chain, each with a chain model.
// Readback expectations are exercised when CCFF_READBACK_EN is defined.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start16, start12;
  logic head16, sen16, tail16, busy16, done16, rbv16;
  logic head12, sen12, tail12, busy12, done12, rbv12;
  logic [7:0] rbd16, rbd12;

  ccff_bitstream_loader_if #(.WORD_W(8)) bs16 ();
  ccff_bitstream_loader_if #(.WORD_W(8)) bs12 ();

  ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(clk), .prog_reset(rst_n), .start(start16), .bs(bs16),
    .ccff_head(head16), .ccff_shift_en(sen16), .ccff_tail(tail16),
    .busy(busy16), .cfg_done(done16), .rb_data(rbd16), .rb_valid(rbv16)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clk(clk), .prog_reset(rst_n), .start(start12), .bs(bs12),
    .ccff_head(head12), .ccff_shift_en(sen12), .ccff_tail(tail12),
    .busy(busy12), .cfg_done(done12), .rb_data(rbd12), .rb_valid(rbv12)
  );

  // Fabric chain models: shift on the prog_clk edge ending a shift_en cycle.
  logic [15:0] chain16 = '0;
  logic [11:0] chain12 = '0;
  assign tail16 = chain16[15];
  assign tail12 = chain12[11];
  always @(posedge clk) if (sen16) chain16 <= {chain16[14:0], head16};
  always @(posedge clk) if (sen12) chain12 <= {chain12[10:0], head12};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int sh16 = 0, first16 = -1, last16 = -1, donecyc16 = -1, acc16 = 0, rbn16 = 0, start_cyc16 = 0;
  int sh12 = 0, first12 = -1, last12 = -1, donecyc12 = -1, acc12 = 0, rbn12 = 0, start_cyc12 = 0;
  logic [31:0] bits16 = '0, bits12 = '0;
  logic [15:0] rbw16 = '0, rbw12 = '0;
  logic prev_done16 = 1'b0, prev_done12 = 1'b0;

  // Monitor samples mid-low-phase, after the bench has driven this cycle's inputs.
  always @(negedge clk) begin
    #1;
    if (sen16) begin
      sh16++;
      bits16 = {bits16[30:0], head16};
      if (first16 < 0) first16 = cyc;
      last16 = cyc;
    end
    if (done16 && !prev_done16) donecyc16 = cyc;
    prev_done16 = done16;
    if (bs16.bs_valid && bs16.bs_ready) acc16++;
    if (rbv16) begin rbn16++; rbw16 = {rbw16[7:0], rbd16}; end
    if (sen12) begin
      sh12++;
      bits12 = {bits12[30:0], head12};
      if (first12 < 0) first12 = cyc;
      last12 = cyc;
    end
    if (done12 && !prev_done12) donecyc12 = cyc;
    prev_done12 = done12;
    if (bs12.bs_valid && bs12.bs_ready) acc12++;
    if (rbv12) begin rbn12++; rbw12 = {rbw12[7:0], rbd12}; end
  end

  task automatic clear_mon16;
    sh16 = 0; first16 = -1; last16 = -1; donecyc16 = -1; acc16 = 0; bits16 = '0;
  endtask

  task automatic clear_mon12;
    sh12 = 0; first12 = -1; last12 = -1; donecyc12 = -1; acc12 = 0; bits12 = '0;
  endtask

  task automatic pulse_start(input bit sel12);
    if (sel12) begin start12 = 1'b1; start_cyc12 = cyc; end
    else       begin start16 = 1'b1; start_cyc16 = cyc; end
    @(negedge clk);
    start12 = 1'b0;
    start16 = 1'b0;
  endtask

  // Holds the word valid until a ready cycle; returns on the negedge after acceptance.
  task automatic send_word(input bit sel12, input logic [7:0] w, output bit ok);
    ok = 1'b0;
    if (sel12) begin bs12.bs_data = w; bs12.bs_valid = 1'b1; end
    else       begin bs16.bs_data = w; bs16.bs_valid = 1'b1; end
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = sel12 ? (bs12.bs_ready === 1'b1) : (bs16.bs_ready === 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input bit sel12, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = sel12 ? (done12 === 1'b1) : (done16 === 1'b1);
      if (!ok) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if ({head16, sen16, busy16, done16, bs16.bs_ready, rbv16, rbd16} !== 14'h0) begin
      errors++;
      $display("FAIL reset16_outputs got %b expected all zero",
               {head16, sen16, busy16, done16, bs16.bs_ready, rbv16, rbd16});
    end
    checks++;
    if ({head12, sen12, busy12, done12, bs12.bs_ready, rbv12, rbd12} !== 14'h0) begin
      errors++;
      $display("FAIL reset12_outputs got %b expected all zero",
               {head12, sen12, busy12, done12, bs12.bs_ready, rbv12, rbd12});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy16, done16, bs16.bs_ready, sen16} !== 4'b0000) begin
      errors++;
      $display("FAIL idle16_after_reset got %b expected 0000", {busy16, done16, bs16.bs_ready, sen16});
    end
    checks++;
    if ({busy12, done12, bs12.bs_ready, sen12} !== 4'b0000) begin
      errors++;
      $display("FAIL idle12_after_reset got %b expected 0000", {busy12, done12, bs12.bs_ready, sen12});
    end
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2, okd;
    clear_mon16();
    pulse_start(1'b0);
    send_word(1'b0, 8'hA5, ok1);
    send_word(1'b0, 8'h3C, ok2);
    bs16.bs_valid = 1'b0;
    wait_done(1'b0, okd);
    checks++;
    if ({ok1, ok2, okd} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_handshake got %b expected 111 (accept, accept, done)", {ok1, ok2, okd});
    end
    checks++;
    if (bits16[15:0] !== 16'hA53C) begin
      errors++;
      $display("FAIL b2b_head_sequence got %h expected a53c", bits16[15:0]);
    end
    checks++;
    if (sh16 !== 16 || last16 - first16 + 1 !== 16) begin
      errors++;
      $display("FAIL b2b_shift_window got count %0d span %0d expected 16 16", sh16, last16 - first16 + 1);
    end
    checks++;
    if (last16 - start_cyc16 !== 17) begin
      errors++;
      $display("FAIL b2b_load_time got %0d expected 17", last16 - start_cyc16);
    end
    checks++;
    if (donecyc16 - last16 !== 1) begin
      errors++;
      $display("FAIL b2b_done_latency got %0d expected 1", donecyc16 - last16);
    end
    checks++;
    if (chain16 !== 16'hA53C || busy16 !== 1'b0 || bs16.bs_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final_state got chain %h busy %b ready %b expected a53c 0 0",
               chain16, busy16, bs16.bs_ready);
    end
  endtask

  task automatic test_bubble;
    bit ok1, ok2, okd;
    clear_mon16();
    pulse_start(1'b0);
    send_word(1'b0, 8'hA5, ok1);
    bs16.bs_valid = 1'b0;
    for (int i = 0; i < 20 && sen16 === 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({sen16, head16, bs16.bs_ready} !== 3'b011) begin
        errors++;
        $display("FAIL bubble_gap%0d got shift_en,head,ready %b expected 011", i, {sen16, head16, bs16.bs_ready});
      end
      @(negedge clk);
    end
    send_word(1'b0, 8'h3C, ok2);
    bs16.bs_valid = 1'b0;
    wait_done(1'b0, okd);
    checks++;
    if ({ok1, ok2, okd} !== 3'b111) begin
      errors++;
      $display("FAIL bubble_handshake got %b expected 111", {ok1, ok2, okd});
    end
    checks++;
    if (sh16 !== 16 || chain16 !== 16'hA53C || bits16[15:0] !== 16'hA53C) begin
      errors++;
      $display("FAIL bubble_chain got count %0d chain %h head %h expected 16 a53c a53c",
               sh16, chain16, bits16[15:0]);
    end
    // 8 shifts, 6 stalled cycles, 8 shifts.
    checks++;
    if (last16 - first16 + 1 !== 22) begin
      errors++;
      $display("FAIL bubble_span got %0d expected 22", last16 - first16 + 1);
    end
  endtask

  task automatic test_partial;
    bit ok1, ok2, okd;
    clear_mon12();
    pulse_start(1'b1);
    send_word(1'b1, 8'hFF, ok1);
    send_word(1'b1, 8'h9F, ok2);
    bs12.bs_data = 8'h55;
    wait_done(1'b1, okd);
    repeat (3) @(negedge clk);
    checks++;
    if ({ok1, ok2, okd} !== 3'b111) begin
      errors++;
      $display("FAIL partial_handshake got %b expected 111", {ok1, ok2, okd});
    end
    checks++;
    if (acc12 !== 2) begin
      errors++;
      $display("FAIL partial_words_accepted got %0d expected 2", acc12);
    end
    checks++;
    if (sh12 !== 12 || bits12[11:0] !== 12'hFF9) begin
      errors++;
      $display("FAIL partial_head_sequence got count %0d bits %h expected 12 ff9", sh12, bits12[11:0]);
    end
    checks++;
    if (chain12 !== 12'hFF9 || done12 !== 1'b1 || bs12.bs_ready !== 1'b0) begin
      errors++;
      $display("FAIL partial_final_state got chain %h done %b ready %b expected ff9 1 0",
               chain12, done12, bs12.bs_ready);
    end
    bs12.bs_valid = 1'b0;
  endtask

  task automatic test_start;
    bit ok1, ok2, okd;
    checks++;
    if (done16 !== 1'b1) begin
      errors++;
      $display("FAIL start_pre_done got %b expected 1", done16);
    end
    clear_mon16();
    pulse_start(1'b0);
    checks++;
    if ({done16, busy16, bs16.bs_ready} !== 3'b011) begin
      errors++;
      $display("FAIL start_reload got done,busy,ready %b expected 011", {done16, busy16, bs16.bs_ready});
    end
    send_word(1'b0, 8'h5A, ok1);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    checks++;
    if ({busy16, sen16, bs16.bs_ready} !== 3'b110) begin
      errors++;
      $display("FAIL start_while_busy got busy,shift_en,ready %b expected 110", {busy16, sen16, bs16.bs_ready});
    end
    send_word(1'b0, 8'hC3, ok2);
    bs16.bs_valid = 1'b0;
    wait_done(1'b0, okd);
    checks++;
    if ({ok1, ok2, okd} !== 3'b111) begin
      errors++;
      $display("FAIL start_handshake got %b expected 111", {ok1, ok2, okd});
    end
    checks++;
    if (chain16 !== 16'h5AC3 || sh16 !== 16) begin
      errors++;
      $display("FAIL start_reload_chain got chain %h count %0d expected 5ac3 16", chain16, sh16);
    end
    checks++;
    if (last16 - start_cyc16 !== 17 || donecyc16 - last16 !== 1) begin
      errors++;
      $display("FAIL start_reload_timing got load %0d done %0d expected 17 1",
               last16 - start_cyc16, donecyc16 - last16);
    end
  endtask

  task automatic test_readback;
`ifdef CCFF_READBACK_EN
    bit ok1, ok2, okd;
    chain16 = 16'h1234;
    rbn16 = 0; rbw16 = '0;
    pulse_start(1'b0);
    send_word(1'b0, 8'hA5, ok1);
    send_word(1'b0, 8'h3C, ok2);
    bs16.bs_valid = 1'b0;
    wait_done(1'b0, okd);
    checks++;
    if (rbn16 !== 2 || rbw16 !== 16'h1234) begin
      errors++;
      $display("FAIL readback16 got pulses %0d words %h expected 2 1234", rbn16, rbw16);
    end
    chain12 = 12'hFF9;
    rbn12 = 0; rbw12 = '0;
    pulse_start(1'b1);
    send_word(1'b1, 8'hFF, ok1);
    send_word(1'b1, 8'h9F, ok2);
    bs12.bs_valid = 1'b0;
    wait_done(1'b1, okd);
    checks++;
    if (rbn12 !== 2 || rbw12 !== 16'hFF90) begin
      errors++;
      $display("FAIL readback12_partial got pulses %0d words %h expected 2 ff90", rbn12, rbw12);
    end
`else
    checks++;
    if (rbn16 !== 0 || rbn12 !== 0 || rbd16 !== 8'h00 || rbd12 !== 8'h00) begin
      errors++;
      $display("FAIL readback_tied_off got pulses %0d %0d data %h %h expected 0 0 00 00",
               rbn16, rbn12, rbd16, rbd12);
    end
`endif
  endtask

  task automatic test_reset_mid_load;
    bit ok1, ok2, okd;
    pulse_start(1'b0);
    send_word(1'b0, 8'hA5, ok1);
    repeat (2) @(negedge clk);
    checks++;
    if ({ok1, sen16, head16, busy16} !== 4'b1111) begin
      errors++;
      $display("FAIL midreset_pre got accept,shift_en,head,busy %b expected 1111", {ok1, sen16, head16, busy16});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({head16, sen16, busy16, done16, bs16.bs_ready, rbv16, rbd16} !== 14'h0) begin
      errors++;
      $display("FAIL midreset_async got %b expected all zero",
               {head16, sen16, busy16, done16, bs16.bs_ready, rbv16, rbd16});
    end
    bs16.bs_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy16, done16, bs16.bs_ready, sen16} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_idle got %b expected 0000", {busy16, done16, bs16.bs_ready, sen16});
    end
    clear_mon16();
    pulse_start(1'b0);
    send_word(1'b0, 8'h12, ok1);
    send_word(1'b0, 8'h34, ok2);
    bs16.bs_valid = 1'b0;
    wait_done(1'b0, okd);
    checks++;
    if ({ok1, ok2, okd} !== 3'b111 || chain16 !== 16'h1234 || sh16 !== 16) begin
      errors++;
      $display("FAIL midreset_reload got hs %b chain %h count %0d expected 111 1234 16",
               {ok1, ok2, okd}, chain16, sh16);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start16 = 1'b0; start12 = 1'b0;
    bs16.bs_valid = 1'b0; bs16.bs_data = '0;
    bs12.bs_valid = 1'b0; bs12.bs_data = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_bubble();
    test_partial();
    test_start();
    test_readback();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete within 100000 time units");
    $fatal(1);
  end

endmodule
